ftdi_fifo_ctrl: RTL and testbench

- Drives the FT232H asynchronous 245-FIFO pins: RXF#, TXE#, RD#, WR# and the 8-bit ADBUS, including the ADBUS tristate enable.
- Converts them into two valid/ready byte streams for the LaserDrop core: host-to-laser (rx) and laser-to-host (tx).
- Sits between the board-level pin mapping and the laser framing logic.
- Owns all FTDI strobe timing, bus turnaround and read/write arbitration.

---
 rtl/ftdi_fifo_ctrl_pkg.sv | 27 ++
 rtl/ftdi_fifo_ctrl_if.sv | 33 +++
 rtl/ftdi_fifo_ctrl_sync.sv | 26 ++
 rtl/ftdi_fifo_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ftdi_fifo_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ftdi_fifo_ctrl_pkg.sv
// rtl/ftdi_fifo_ctrl_pkg.sv - shared types and default timing for the FT232H 245-FIFO controller
// Purpose: FSM state and direction enums plus default strobe timing constants.
// Ports: none (package).
package laserdrop_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LOW,
        RD_RECOVER,
        WR_SETUP,
        WR_LOW,
        WR_HOLD,
        WR_RECOVER
    } ftdi_state_t;

    typedef enum logic {
        READ,
        WRITE
    } dir_t;

    localparam int FTDI_RD_LOW   = 3;
    localparam int FTDI_WR_SETUP = 1;
    localparam int FTDI_WR_LOW   = 3;
    localparam int FTDI_RECOVER  = 3;
    localparam int FTDI_SYNC     = 2;

endpackage

// File: rtl/ftdi_fifo_ctrl_if.sv
// rtl/ftdi_fifo_ctrl_if.sv - FTDI pin and byte-stream bundle for ftdi_fifo_ctrl
// Purpose: groups FTDI pins, rx/tx byte streams and byte counters.
// Ports: slave = controller side (drives pins/rx stream/counters), master = board/core side.
interface ftdi_fifo_ctrl_if;
    logic        en;
    logic        rxf;
    logic        txe;
    logic [7:0]  adbus_in;
    logic        ftdi_rd;
    logic        ftdi_wr;
    logic [7:0]  adbus_out;
    logic        adbus_tri;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_count;
    logic [15:0] tx_count;

    modport slave (
        input  en, rxf, txe, adbus_in, rx_ready, tx_data, tx_valid,
        output ftdi_rd, ftdi_wr, adbus_out, adbus_tri, rx_data, rx_valid,
               tx_ready, rx_count, tx_count
    );

    modport master (
        output en, rxf, txe, adbus_in, rx_ready, tx_data, tx_valid,
        input  ftdi_rd, ftdi_wr, adbus_out, adbus_tri, rx_data, rx_valid,
               tx_ready, rx_count, tx_count
    );
endinterface

// File: rtl/ftdi_fifo_ctrl_sync.sv
// rtl/ftdi_fifo_ctrl_sync.sv - multi-flop synchronizer for asynchronous FTDI status pins
// Purpose: brings one asynchronous bit into the clock domain through STAGES flops.
// Ports: clock, reset (async active-high), d_i (async input), q_o (synchronized output).
module sync_2ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ftdi_fifo_ctrl.sv
// rtl/ftdi_fifo_ctrl.sv - FT232H asynchronous 245-FIFO strobe controller with rx/tx byte streams
// Purpose: owns RD#/WR# timing, ADBUS turnaround and read/write arbitration.
// Ports: clock, reset (async active-high), bus (ftdi_fifo_ctrl_if.slave: FTDI pins,
//        rx/tx valid/ready byte streams, rx/tx byte counters).
module ftdi_fifo_ctrl
    import laserdrop_pkg::*;
#(
    parameter int RD_LOW_CYCLES   = FTDI_RD_LOW,
    parameter int WR_SETUP_CYCLES = FTDI_WR_SETUP,
    parameter int WR_LOW_CYCLES   = FTDI_WR_LOW,
    parameter int RECOVER_CYCLES  = FTDI_RECOVER,
    parameter int SYNC_STAGES     = FTDI_SYNC
) (
    input  logic           clock,
    input  logic           reset,
    ftdi_fifo_ctrl_if.slave bus
);

    // Recovery must outlast the synchronizer so a stale RXF#/TXE# is never acted on.
    if (RECOVER_CYCLES < SYNC_STAGES + 1) begin : g_bad_recover
        $error("RECOVER_CYCLES must be at least SYNC_STAGES+1");
    end
    if (RD_LOW_CYCLES < 2 || WR_LOW_CYCLES < 2 || WR_SETUP_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_timing
        $error("strobe timing parameters below minimum");
    end

    logic rxf_s;
    logic txe_s;

    // Reset to 1 so the FIFO reads as not-ready until real samples arrive.
    sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rxf (
        .clock (clock),
        .reset (reset),
        .d_i   (bus.rxf),
        .q_o   (rxf_s)
    );

    sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_txe (
        .clock (clock),
        .reset (reset),
        .d_i   (bus.txe),
        .q_o   (txe_s)
    );

    ftdi_state_t state_q, state_d;
    dir_t        last_dir_q, last_dir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        tri_q, tri_d;
    logic [7:0]  adbus_out_q, adbus_out_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic [15:0] rx_count_q, rx_count_d;
    logic [15:0] tx_count_q, tx_count_d;

    logic can_rd;
    logic can_wr;
    logic rd_grant;
    logic wr_grant;
    logic tx_ready;
    logic wr_fire;

    // A read may start when the holding register is empty or is being drained this cycle.
    assign can_rd   = bus.en && !rxf_s && (!rx_valid_q || bus.rx_ready);
    assign can_wr   = bus.en && !txe_s && bus.tx_valid;
    // Write grant deliberately ignores tx_valid so tx_ready never depends on it.
    assign wr_grant = !can_rd || (last_dir_q == READ);
    assign rd_grant = can_rd && (!can_wr || (last_dir_q == WRITE));
    assign tx_ready = (state_q == IDLE) && bus.en && !txe_s && wr_grant;
    assign wr_fire  = bus.tx_valid && tx_ready;

    always_comb begin
        state_d     = state_q;
        last_dir_d  = last_dir_q;
        cnt_d       = cnt_q + 8'd1;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        tri_d       = tri_q;
        adbus_out_d = adbus_out_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_count_d  = rx_count_q;
        tx_count_d  = tx_count_q;

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (rd_grant) begin
                    state_d    = RD_LOW;
                    rd_n_d     = 1'b0;
                    last_dir_d = READ;
                end else if (wr_fire) begin
                    state_d     = WR_SETUP;
                    tri_d       = 1'b1;
                    adbus_out_d = bus.tx_data;
                    last_dir_d  = WRITE;
                end
            end
            RD_LOW: begin
                if (cnt_q == 8'(RD_LOW_CYCLES - 1)) begin
                    state_d    = RD_RECOVER;
                    cnt_d      = 8'd0;
                    rd_n_d     = 1'b1;
                    rx_data_d  = bus.adbus_in;
                    rx_valid_d = 1'b1;
                    rx_count_d = rx_count_q + 16'd1;
                end
            end
            RD_RECOVER: begin
                if (cnt_q == 8'(RECOVER_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            WR_SETUP: begin
                if (cnt_q == 8'(WR_SETUP_CYCLES - 1)) begin
                    state_d = WR_LOW;
                    cnt_d   = 8'd0;
                    wr_n_d  = 1'b0;
                end
            end
            WR_LOW: begin
                if (cnt_q == 8'(WR_LOW_CYCLES - 1)) begin
                    state_d    = WR_HOLD;
                    cnt_d      = 8'd0;
                    wr_n_d     = 1'b1;
                    tx_count_d = tx_count_q + 16'd1;
                end
            end
            WR_HOLD: begin
                // One cycle of data hold after WR# rises before releasing the bus.
                state_d = WR_RECOVER;
                cnt_d   = 8'd0;
                tri_d   = 1'b0;
            end
            WR_RECOVER: begin
                if (cnt_q == 8'(RECOVER_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                rd_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                tri_d   = 1'b0;
            end
        endcase
    end

    // Strobes and bus enable are registered so reset releases them asynchronously and glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_dir_q  <= WRITE;
            cnt_q       <= 8'd0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            tri_q       <= 1'b0;
            adbus_out_q <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_count_q  <= 16'd0;
            tx_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            last_dir_q  <= last_dir_d;
            cnt_q       <= cnt_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            tri_q       <= tri_d;
            adbus_out_q <= adbus_out_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_count_q  <= rx_count_d;
            tx_count_q  <= tx_count_d;
        end
    end

    assign bus.ftdi_rd   = rd_n_q;
    assign bus.ftdi_wr   = wr_n_q;
    assign bus.adbus_tri = tri_q;
    assign bus.adbus_out = adbus_out_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.tx_ready  = tx_ready;
    assign bus.rx_count  = rx_count_q;
    assign bus.tx_count  = tx_count_q;

endmodule

// File: tb/tb_ftdi_fifo_ctrl.sv
// tb/tb_ftdi_fifo_ctrl.sv - self-checking bench for ftdi_fifo_ctrl
module tb_ftdi_fifo_ctrl;

    localparam logic [7:0] EV_R = 8'h52;
    localparam logic [7:0] EV_W = 8'h57;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ftdi_fifo_ctrl_if bus();

    ftdi_fifo_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] ev_q[$];
    logic       prev_rd = 1'b1;
    logic       prev_wr = 1'b1;
    logic [7:0] mon_e8;

    // Scoreboard monitor: pops expected bytes as the DUT delivers them and logs strobe starts.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            total++;
            if ((!bus.ftdi_rd && bus.adbus_tri) || (!bus.ftdi_rd && !bus.ftdi_wr)) begin
                bad++;
                $display("FAIL bus_invariant rd=%b wr=%b tri=%b required no rd-low with tri or both low",
                         bus.ftdi_rd, bus.ftdi_wr, bus.adbus_tri);
            end
            if (bus.rx_valid && bus.rx_ready) begin
                total++;
                if (rx_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rx_unexpected got=%h required=none", bus.rx_data);
                end else begin
                    mon_e8 = rx_exp_q.pop_front();
                    if (bus.rx_data !== mon_e8) begin
                        bad++;
                        $display("FAIL rx_data got=%h required=%h", bus.rx_data, mon_e8);
                    end
                end
            end
            if (prev_rd && !bus.ftdi_rd) ev_q.push_back(EV_R);
            if (prev_wr && !bus.ftdi_wr) begin
                ev_q.push_back(EV_W);
                total++;
                if (tx_exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tx_unexpected got=%h required=none", bus.adbus_out);
                end else begin
                    mon_e8 = tx_exp_q.pop_front();
                    if (bus.adbus_out !== mon_e8 || bus.adbus_tri !== 1'b1) begin
                        bad++;
                        $display("FAIL tx_adbus got=%h tri=%b required=%h tri=1", bus.adbus_out, bus.adbus_tri, mon_e8);
                    end
                end
            end
        end
        prev_rd = bus.ftdi_rd;
        prev_wr = bus.ftdi_wr;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset(input logic en_v, input logic rxf_v, input logic txe_v, input logic txv_v,
                            input logic rdy_v, input logic [7:0] txd_v, input logic [7:0] ad_v);
        reset        = 1'b1;
        bus.en       = en_v;
        bus.rxf      = rxf_v;
        bus.txe      = txe_v;
        bus.tx_valid = txv_v;
        bus.rx_ready = rdy_v;
        bus.tx_data  = txd_v;
        bus.adbus_in = ad_v;
        rx_exp_q.delete();
        tx_exp_q.delete();
        ev_q.delete();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_tx_handshake(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (bus.tx_ready && bus.tx_valid) ok = 1'b1;
            tick();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tx_handshake_timeout got=none required=handshake within 12 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.en = 1'b1; bus.rxf = 1'b0; bus.txe = 1'b0; bus.tx_valid = 1'b1;
        bus.rx_ready = 1'b1; bus.tx_data = 8'hFF; bus.adbus_in = 8'hFF;
        repeat (3) tick();
        total++;
        if ({bus.ftdi_rd, bus.ftdi_wr, bus.adbus_tri, bus.rx_valid, bus.tx_ready} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=11000",
                     {bus.ftdi_rd, bus.ftdi_wr, bus.adbus_tri, bus.rx_valid, bus.tx_ready});
        end
        total++;
        if ({bus.adbus_out, bus.rx_data, bus.rx_count, bus.tx_count} !== 48'd0) begin
            bad++;
            $display("FAIL reset_data got=%h %h %h %h required=0", bus.adbus_out, bus.rx_data, bus.rx_count, bus.tx_count);
        end
    endtask

    task automatic test_read();
        logic [7:0] obs;
        do_reset(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA5);
        rx_exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            tick();
            obs[i] = bus.ftdi_rd;
            if (i == 3) bus.rxf = 1'b1;
            if (i == 5) begin
                total++;
                if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'hA5) begin
                    bad++;
                    $display("FAIL read_valid got=%b/%h required=1/a5", bus.rx_valid, bus.rx_data);
                end
            end
            if (i == 6) begin
                total++;
                if (bus.rx_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL read_pulse got=%b required=0", bus.rx_valid);
                end
            end
        end
        total++;
        if (obs !== 8'hE3) begin
            bad++;
            $display("FAIL read_rd_timing got=%b required=11100011", obs);
        end
        repeat (6) tick();
        total++;
        if (bus.rx_count !== 16'd1 || rx_exp_q.size() != 0 || ev_q.size() != 1) begin
            bad++;
            $display("FAIL read_count got=%0d left=%0d strobes=%0d required=1 0 1", bus.rx_count, rx_exp_q.size(), ev_q.size());
        end
    endtask

    task automatic test_write();
        bit ok;
        logic [6:0] obs_wr, obs_tri;
        do_reset(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h00);
        tx_exp_q.push_back(8'h3C);
        wait_tx_handshake(ok);
        bus.tx_valid = 1'b0;
        total++;
        if (bus.adbus_out !== 8'h3C || bus.tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL write_latch got=%h rdy=%b required=3c rdy=0", bus.adbus_out, bus.tx_ready);
        end
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            obs_wr[i]  = bus.ftdi_wr;
            obs_tri[i] = bus.adbus_tri;
        end
        total++;
        if (obs_wr !== 7'h71) begin
            bad++;
            $display("FAIL write_wr_timing got=%b required=1110001", obs_wr);
        end
        total++;
        if (obs_tri !== 7'h1F) begin
            bad++;
            $display("FAIL write_tri_timing got=%b required=0011111", obs_tri);
        end
        repeat (4) tick();
        total++;
        if (bus.tx_count !== 16'd1 || bus.rx_count !== 16'd0 || tx_exp_q.size() != 0) begin
            bad++;
            $display("FAIL write_count got=%0d/%0d left=%0d required=1/0 0", bus.tx_count, bus.rx_count, tx_exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] dir_exp[$];
        logic [7:0] got;
        logic [7:0] want;
        logic       prev_t = 1'b1;
        do_reset(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h20);
        dir_exp = {EV_R, EV_W, EV_R, EV_W};
        for (int i = 0; i < 80 && ev_q.size() < 4; i++) begin
            if (bus.tx_ready && bus.tx_valid) begin
                tx_exp_q.push_back(bus.tx_data);
                tick();
                bus.tx_data = bus.tx_data + 8'd1;
            end else begin
                tick();
            end
            if (prev_t && !bus.ftdi_rd) rx_exp_q.push_back(bus.adbus_in);
            if (!prev_t && bus.ftdi_rd) bus.adbus_in = bus.adbus_in + 8'd1;
            prev_t = bus.ftdi_rd;
        end
        bus.rxf = 1'b1;
        bus.tx_valid = 1'b0;
        repeat (14) tick();
        total++;
        if (ev_q.size() != 4) begin
            bad++;
            $display("FAIL b2b_strobes got=%0d required=4", ev_q.size());
        end
        for (int i = 0; i < 4 && ev_q.size() > 0; i++) begin
            got  = ev_q.pop_front();
            want = dir_exp.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL b2b_order idx=%0d got=%c required=%c", i, got, want);
            end
        end
        total++;
        if (bus.rx_count !== 16'd2 || bus.tx_count !== 16'd2 || rx_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count got=%0d/%0d left=%0d/%0d required=2/2 0/0",
                     bus.rx_count, bus.tx_count, rx_exp_q.size(), tx_exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        do_reset(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h5A);
        rx_exp_q.push_back(8'h5A);
        repeat (10) tick();
        bus.adbus_in = 8'h77;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rx_data !== 8'h5A || bus.rx_valid !== 1'b1 || bus.ftdi_rd !== 1'b1) unstable++;
        end
        total++;
        if (unstable != 0 || ev_q.size() != 1 || bus.rx_count !== 16'd1) begin
            bad++;
            $display("FAIL bp_hold got=unstable %0d strobes %0d count %0d required=0 1 1", unstable, ev_q.size(), bus.rx_count);
        end
        rx_exp_q.push_back(8'h77);
        bus.rx_ready = 1'b1;
        tick();
        total++;
        if (bus.ftdi_rd !== 1'b0) begin
            bad++;
            $display("FAIL bp_second_read got=%b required=0", bus.ftdi_rd);
        end
        bus.rxf = 1'b1;
        repeat (10) tick();
        total++;
        if (bus.rx_count !== 16'd2 || rx_exp_q.size() != 0 || ev_q.size() != 2) begin
            bad++;
            $display("FAIL bp_count got=%0d left=%0d strobes=%0d required=2 0 2", bus.rx_count, rx_exp_q.size(), ev_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        do_reset(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h00);
        tx_exp_q.push_back(8'hC3);
        wait_tx_handshake(ok);
        bus.tx_valid = 1'b0;
        repeat (2) tick();
        total++;
        if (bus.ftdi_wr !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_pre got=%b required=0", bus.ftdi_wr);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.ftdi_wr, bus.adbus_tri, bus.ftdi_rd} !== 3'b101 || bus.tx_count !== 16'd0) begin
            bad++;
            $display("FAIL rst_mid_async got=wr%b tri%b rd%b cnt%0d required=wr1 tri0 rd1 cnt0",
                     bus.ftdi_wr, bus.adbus_tri, bus.ftdi_rd, bus.tx_count);
        end
        total++;
        if (tx_exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_sb got=%0d required=0", tx_exp_q.size());
        end
        tick();
    endtask

    task automatic test_enable();
        int active = 0;
        do_reset(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 8'h11);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.ftdi_rd || !bus.ftdi_wr || bus.tx_ready) active++;
        end
        total++;
        if (active != 0 || ev_q.size() != 0) begin
            bad++;
            $display("FAIL en_idle got=%0d active %0d strobes required=0 0", active, ev_q.size());
        end
        rx_exp_q.push_back(8'h11);
        bus.en = 1'b1;
        tick();
        total++;
        if (bus.ftdi_rd !== 1'b0) begin
            bad++;
            $display("FAIL en_start got=%b required=0", bus.ftdi_rd);
        end
        bus.en = 1'b0;
        repeat (12) tick();
        total++;
        if (bus.rx_count !== 16'd1 || bus.tx_count !== 16'd0 || ev_q.size() != 1 || rx_exp_q.size() != 0) begin
            bad++;
            $display("FAIL en_drop got=%0d/%0d strobes=%0d left=%0d required=1/0 1 0",
                     bus.rx_count, bus.tx_count, ev_q.size(), rx_exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_write();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
